// File: rtl/mem_arbiter_pkg.sv
// Shared types for the unified-memory arbiter: FSM state codes and bus-owner codes.
package mem_arbiter_pkg;

  localparam int MEM_ARB_STATE_WIDTH = 2;

  typedef enum logic [MEM_ARB_STATE_WIDTH-1:0] {
    MEM_ARB_IDLE = 2'd0,
    MEM_ARB_REQ  = 2'd1,
    MEM_ARB_WAIT = 2'd2
  } state_t;

  typedef enum logic {
    MEM_ARB_OWN_IF  = 1'b0,
    MEM_ARB_OWN_MEM = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data ports onto one single-port memory bus (IDLE/REQ/WAIT).
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin contention; default is data-over-fetch.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  input  logic                    flush_if,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  output logic                    if_valid,
  input  logic                    mem_req,
  input  logic                    mem_wr,
  input  logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH/8-1:0] mem_be,
  output logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    mem_valid,
  output logic                    stall_if,
  output logic                    stall_mem,
  output logic                    bus_req,
  output logic                    bus_we,
  output logic [ADDR_WIDTH-1:0]   bus_addr,
  output logic [DATA_WIDTH-1:0]   bus_wdata,
  output logic [DATA_WIDTH/8-1:0] bus_be,
  input  logic                    bus_gnt,
  input  logic                    bus_rvalid,
  input  logic [DATA_WIDTH-1:0]   bus_rdata
);

  state_t state;
  owner_t owner;
  logic   discard;
  logic   if_elig;
  logic   mem_elig;
  logic   pick_mem;

  // A port whose response is on the wire this cycle is masked so its held req is not re-issued.
  assign if_elig  = if_req & ~if_valid;
  assign mem_elig = mem_req & ~mem_valid;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  owner_t last_gnt;
  assign pick_mem = mem_elig & (~if_elig | (last_gnt == MEM_ARB_OWN_IF));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt <= MEM_ARB_OWN_IF;
    end else if (state == MEM_ARB_IDLE && (if_elig | mem_elig)) begin
      last_gnt <= pick_mem ? MEM_ARB_OWN_MEM : MEM_ARB_OWN_IF;
    end
  end
`else
  assign pick_mem = mem_elig;
`endif

  assign stall_if  = ~rst & if_req & ~if_valid;
  assign stall_mem = ~rst & mem_req & ~mem_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= MEM_ARB_IDLE;
      owner     <= MEM_ARB_OWN_IF;
      discard   <= 1'b0;
      if_rdata  <= '0;
      if_valid  <= 1'b0;
      mem_rdata <= '0;
      mem_valid <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_be    <= '0;
    end else begin
      if_valid  <= 1'b0;
      mem_valid <= 1'b0;
      case (state)
        MEM_ARB_IDLE: begin
          if (if_elig | mem_elig) begin
            state   <= MEM_ARB_REQ;
            bus_req <= 1'b1;
            if (pick_mem) begin
              owner     <= MEM_ARB_OWN_MEM;
              bus_we    <= mem_wr;
              bus_addr  <= mem_addr;
              bus_wdata <= mem_wdata;
              bus_be    <= mem_be;
              discard   <= 1'b0;
            end else begin
              owner     <= MEM_ARB_OWN_IF;
              bus_we    <= 1'b0;
              bus_addr  <= if_addr;
              bus_wdata <= '0;
              bus_be    <= '1;
              discard   <= flush_if;
            end
          end
        end
        MEM_ARB_REQ: begin
          if (owner == MEM_ARB_OWN_IF && flush_if) discard <= 1'b1;
          if (bus_gnt) begin
            bus_req <= 1'b0;
            state   <= MEM_ARB_WAIT;
          end
        end
        MEM_ARB_WAIT: begin
          if (owner == MEM_ARB_OWN_IF && flush_if) discard <= 1'b1;
          if (bus_rvalid) begin
            state   <= MEM_ARB_IDLE;
            discard <= 1'b0;
            if (owner == MEM_ARB_OWN_MEM) begin
              mem_valid <= 1'b1;
              if (!bus_we) mem_rdata <= bus_rdata;
            end else if (!(discard | flush_if)) begin
              // A flush arriving with the completion still kills the response.
              if_valid <= 1'b1;
              if_rdata <= bus_rdata;
            end
          end
        end
        default: state <= MEM_ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: reference memory model, responsive bus model, directed and random traffic.
module tb_mem_arbiter;

  logic        clk, rst;
  logic        if_req, flush_if, if_valid;
  logic [31:0] if_addr, if_rdata;
  logic        mem_req, mem_wr, mem_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        stall_if, stall_mem;
  logic        bus_req, bus_we, bus_gnt, bus_rvalid;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .flush_if(flush_if),
    .if_rdata(if_rdata), .if_valid(if_valid),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  logic [31:0] if_q[$];
  logic [31:0] mem_q[$];
  logic [31:0] gnt_log[$];
  logic [31:0] bus_mem[logic [31:0]];
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] ref_last = '0;
  logic [31:0] last_if_exp = '0;
  int          gnt_d = 0;
  int          rv_d = 0;
  bit          rand_bus = 0;
  int          n_done = 0;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h13579BDF;
  endfunction

  function automatic void chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: got no response expected valid within 300 cycles", name);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] v;
    v = old;
    for (int i = 0; i < 4; i++) if (be[i]) v[8*i +: 8] = wd[8*i +: 8];
    return v;
  endfunction

  // Bus model: grants after a delay, completes after another, checks payload stability and single outstanding.
  initial begin
    int st, cnt;
    logic [31:0] ca, cw, v;
    logic cwe;
    logic [3:0] cbe;
    st = 0; cnt = 0; ca = '0; cw = '0; cwe = 1'b0; cbe = '0; v = '0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    forever begin
      @(negedge clk);
      bus_gnt = 1'b0;
      bus_rvalid = 1'b0;
      if (rst) begin
        st = 0;
      end else if (st == 0) begin
        if (bus_req) begin
          ca = bus_addr; cwe = bus_we; cw = bus_wdata; cbe = bus_be;
          cnt = rand_bus ? int'($urandom_range(0, 3)) : gnt_d;
          st = 1;
        end
      end else if (st == 1) begin
        chk("bus_hold", {2'b0, bus_req, bus_we, bus_addr, bus_wdata, bus_be}, {2'b0, 1'b1, cwe, ca, cw, cbe});
      end else if (st == 2) begin
        chk("single_outstanding", {71'b0, bus_req}, 72'd0);
        if (cnt == 0) begin
          bus_rvalid = 1'b1;
          v = bus_mem.exists(ca) ? bus_mem[ca] : rom(ca);
          if (cwe) begin
            bus_mem[ca] = merge(v, cw, cbe);
            bus_rdata = $urandom;
          end else begin
            bus_rdata = v;
          end
          n_done++;
          st = 0;
        end else begin
          cnt--;
        end
        continue;
      end
      if (!rst && st == 1) begin
        if (cnt == 0) begin
          bus_gnt = 1'b1;
          gnt_log.push_back(ca);
          cnt = rand_bus ? int'($urandom_range(0, 3)) : rv_d;
          st = 2;
        end else begin
          cnt--;
        end
      end
    end
  end

  // Monitor: pops expected responses whenever a valid pulse appears.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("stall_if", {71'b0, stall_if}, {71'b0, if_req & ~if_valid});
        chk("stall_mem", {71'b0, stall_mem}, {71'b0, mem_req & ~mem_valid});
      end
      if (if_valid) begin
        if (if_q.size() == 0) begin
          total++; bad++;
          $display("FAIL if_unexpected: got if_valid=1 rdata=%h expected no response", if_rdata);
        end else begin
          e = if_q.pop_front();
          chk("if_rdata", {40'b0, if_rdata}, {40'b0, e});
        end
      end
      if (mem_valid) begin
        if (mem_q.size() == 0) begin
          total++; bad++;
          $display("FAIL mem_unexpected: got mem_valid=1 rdata=%h expected no response", mem_rdata);
        end else begin
          e = mem_q.pop_front();
          chk("mem_rdata", {40'b0, mem_rdata}, {40'b0, e});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] a);
    bit got;
    got = 0;
    if_q.push_back(rom(a));
    last_if_exp = rom(a);
    if_addr = a;
    if_req = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (if_valid) begin got = 1; break; end
    end
    if (!got) timeout("if_timeout");
    if_req = 1'b0;
  endtask

  task automatic mem_op(input logic wr, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    bit got;
    logic [31:0] old;
    got = 0;
    old = ref_mem.exists(a) ? ref_mem[a] : rom(a);
    if (wr) begin
      ref_mem[a] = merge(old, wd, be);
      mem_q.push_back(ref_last);
    end else begin
      ref_last = old;
      mem_q.push_back(old);
    end
    mem_wr = wr; mem_addr = a; mem_wdata = wd; mem_be = be;
    mem_req = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (mem_valid) begin got = 1; break; end
    end
    if (!got) timeout("mem_timeout");
    mem_req = 1'b0;
  endtask

  initial begin
    int done0;
    rst = 1'b1;
    if_req = 1'b1; if_addr = '0; flush_if = 1'b0;
    mem_req = 1'b1; mem_wr = 1'b0; mem_addr = '0; mem_wdata = '0; mem_be = '0;
    bus_mem[32'h100] = 32'h00500093;
    repeat (3) tick();
    chk("reset_outputs", {63'b0, bus_req, bus_we, if_valid, mem_valid, stall_if, stall_mem, 3'b0},
        72'd0);
    chk("reset_rdata", {8'b0, if_rdata, mem_rdata}, 72'd0);
    if_req = 1'b0; mem_req = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // Lone fetch at minimum latency.
    gnt_d = 0; rv_d = 0;
    if_addr = 32'h100; if_req = 1'b1;
    if_q.push_back(32'h00500093); last_if_exp = 32'h00500093;
    #1 chk("c0_stall_if", {70'b0, stall_if, bus_req}, {70'b0, 1'b1, 1'b0});
    tick();
    chk("c1_bus", {38'b0, bus_req, bus_we, bus_addr}, {38'b0, 1'b1, 1'b0, 32'h100});
    chk("c1_stall_if", {71'b0, stall_if}, 72'd1);
    tick();
    chk("c2_state", {69'b0, bus_req, stall_if, if_valid}, {69'b0, 1'b0, 1'b1, 1'b0});
    tick();
    chk("c3_valid", {39'b0, if_valid, stall_if, if_rdata}, {39'b0, 1'b1, 1'b0, 32'h00500093});
    if_req = 1'b0;
    tick();

    // Contention from fresh idle: data first, then fetch.
    gnt_log.delete();
    fork
      fetch(32'h1010);
      mem_op(1'b0, 32'h200, '0, 4'h0);
    join
    tick();
    chk("contend_n", 72'(gnt_log.size()), 72'd2);
    if (gnt_log.size() == 2) begin
      chk("contend_first", {40'b0, gnt_log[0]}, {40'b0, 32'h200});
      chk("contend_second", {40'b0, gnt_log[1]}, {40'b0, 32'h1010});
    end

    // Store with withheld grant; then read back the merged word.
    gnt_d = 3; rv_d = 0;
    mem_op(1'b1, 32'h40, 32'hDEADBEEF, 4'b0011);
    gnt_d = 0; rv_d = 1;
    tick();
    mem_op(1'b0, 32'h40, '0, 4'h0);
    tick();

    // Flush during WAIT: bus completes, response dropped, if_rdata kept.
    gnt_d = 0; rv_d = 3;
    done0 = n_done;
    if_addr = 32'h104; if_req = 1'b1;
    tick();
    tick();
    flush_if = 1'b1;
    tick();
    flush_if = 1'b0; if_req = 1'b0;
    repeat (6) tick();
    chk("flush_bus_done", 72'(n_done - done0), 72'd1);
    chk("flush_rdata_kept", {40'b0, if_rdata}, {40'b0, last_if_exp});
    rv_d = 0;
    fetch(32'h200);
    tick();

    // Both ports held for four transactions: response masking alternates them.
    gnt_log.delete();
    fork
      begin fetch(32'h1020); fetch(32'h1024); end
      begin mem_op(1'b0, 32'h2000, '0, 4'h0); mem_op(1'b0, 32'h2004, '0, 4'h0); end
    join
    tick();
    chk("hold4_n", 72'(gnt_log.size()), 72'd4);
    if (gnt_log.size() == 4) begin
      chk("hold4_g0", {40'b0, gnt_log[0]}, {40'b0, 32'h2000});
      chk("hold4_g1", {40'b0, gnt_log[1]}, {40'b0, 32'h1020});
      chk("hold4_g2", {40'b0, gnt_log[2]}, {40'b0, 32'h2004});
      chk("hold4_g3", {40'b0, gnt_log[3]}, {40'b0, 32'h1024});
    end

    // Contention right after a lone data access separates the two policies.
    mem_op(1'b0, 32'h2008, '0, 4'h0);
    tick();
    gnt_log.delete();
    fork
      fetch(32'h1030);
      mem_op(1'b0, 32'h200C, '0, 4'h0);
    join
    tick();
    if (gnt_log.size() >= 1) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      chk("policy_first", {40'b0, gnt_log[0]}, {40'b0, 32'h1030});
`else
      chk("policy_first", {40'b0, gnt_log[0]}, {40'b0, 32'h200C});
`endif
    end else begin
      chk("policy_n", 72'(gnt_log.size()), 72'd2);
    end

    // Reset while the fetch sits in REQ.
    gnt_d = 5;
    if_addr = 32'h300; if_req = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("rst_mid", {68'b0, bus_req, if_valid, mem_valid, stall_if}, 72'd0);
    chk("rst_mid_rdata", {8'b0, if_rdata, mem_rdata}, 72'd0);
    if_req = 1'b0;
    if_q.delete(); mem_q.delete();
    ref_last = '0; last_if_exp = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk("post_rst_idle", {71'b0, bus_req}, 72'd0);
    gnt_d = 0;
    fetch(32'h304);
    tick();

    // Randomized traffic with random bus latencies.
    rand_bus = 1;
    for (int it = 0; it < 30; it++) begin
      fork
        begin
          int n;
          n = $urandom_range(1, 3);
          for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 2)) tick();
            fetch(32'h1000 + 4 * $urandom_range(0, 63));
          end
        end
        begin
          int n;
          n = $urandom_range(1, 3);
          for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 2)) tick();
            mem_op(1'($urandom_range(0, 1)), 32'h2000 + 4 * $urandom_range(0, 7),
                   $urandom, 4'($urandom_range(0, 15)));
          end
        end
      join
    end
    repeat (4) tick();
    chk("if_queue_empty", 72'(if_q.size()), 72'd0);
    chk("mem_queue_empty", 72'(mem_q.size()), 72'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
